// File: rtl/serdes_lane.sv
// serdes_lane: single-lane framed serializer/deserializer.
// TX turns parallel words into start / DATA_W data / [parity] / stop frames on
// tx_serial; RX recovers words from rx_serial (or tx_serial in loopback) with
// mid-bit sampling, start-bit glitch rejection and parity/framing checks.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tx_data, tx_valid        word offered for transmission
//   tx_ready, tx_busy        TX idle / TX frame in progress
//   tx_serial                serial line out, idle high
//   rx_serial                serial line in, asynchronous to clk
//   loopback                 1 = RX listens to tx_serial instead of rx_serial
//   rx_data                  last good received word
//   rx_valid                 one-cycle pulse, rx_data updated
//   rx_parity_err            parity mismatch, qualifies rx_valid
//   rx_frame_err             one-cycle pulse, stop bit sampled low
module serdes_lane #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  input  logic              rx_serial,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              tx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit ODD_PARITY = (PARITY == 2);
  localparam bit LSB_FIRST_B = (LSB_FIRST != 0);

  // Parity bit for a word under the configured mode.
  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ ODD_PARITY;
  endfunction

  // ---------------------------------------------------------------- TX ----
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t         tx_state, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_d;
  logic [IDX_W-1:0]  tx_idx, tx_idx_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d, tx_shift_adv;
  logic              tx_par, tx_par_d;
  logic              tx_serial_d;
  logic              tx_first_bit, tx_next_bit;

  // Current outgoing data bit sits at the shift register's send end.
  always_comb begin
    tx_shift_adv = LSB_FIRST_B ? (tx_shift >> 1) : (tx_shift << 1);
    tx_first_bit = LSB_FIRST_B ? tx_shift[0] : tx_shift[DATA_W-1];
    tx_next_bit  = LSB_FIRST_B ? tx_shift_adv[0] : tx_shift_adv[DATA_W-1];
  end

  // TX next-state and next-output logic.
  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt;
    tx_idx_d    = tx_idx;
    tx_shift_d  = tx_shift;
    tx_par_d    = tx_par;
    tx_serial_d = tx_serial;
    unique case (tx_state)
      TX_IDLE: begin
        tx_serial_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d  = tx_data;
          tx_par_d    = parity_of(tx_data);
          tx_cnt_d    = '0;
          tx_idx_d    = '0;
          tx_serial_d = 1'b0;
          tx_state_d  = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_serial_d = tx_first_bit;
          tx_state_d  = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx == IDX_LAST) begin
            if (HAS_PARITY) begin
              tx_serial_d = tx_par;
              tx_state_d  = TX_PARITY;
            end else begin
              tx_serial_d = 1'b1;
              tx_state_d  = TX_STOP;
            end
          end else begin
            tx_idx_d    = tx_idx + IDX_W'(1);
            tx_shift_d  = tx_shift_adv;
            tx_serial_d = tx_next_bit;
          end
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_serial_d = 1'b1;
          tx_state_d  = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt + CNT_W'(1);
        end
      end
      default: begin
        tx_serial_d = 1'b1;
        tx_state_d  = TX_IDLE;
      end
    endcase
  end

  // TX state and registered outputs; ready/busy track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_idx    <= tx_idx_d;
      tx_shift  <= tx_shift_d;
      tx_par    <= tx_par_d;
      tx_serial <= tx_serial_d;
      tx_ready  <= (tx_state_d == TX_IDLE);
      tx_busy   <= (tx_state_d != TX_IDLE);
    end
  end

  // ---------------------------------------------------------------- RX ----
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  logic              rx_sync1, rx_sync2;
  logic              rx_line;
  rx_state_t         rx_state, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_d;
  logic [IDX_W-1:0]  rx_idx, rx_idx_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d, rx_shift_in;
  logic              rx_par_bit, rx_par_bit_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d, rx_parity_err_d, rx_frame_err_d;

  // Two-flop synchronizer, idles high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
    end else begin
      rx_sync1 <= rx_serial;
      rx_sync2 <= rx_sync1;
    end
  end

  // Loopback taps the already-registered tx_serial, so it needs no sync.
  always_comb begin
    rx_line     = loopback ? tx_serial : rx_sync2;
    rx_shift_in = LSB_FIRST_B ? {rx_line, rx_shift[DATA_W-1:1]}
                              : {rx_shift[DATA_W-2:0], rx_line};
  end

  // RX next-state and next-output logic.
  always_comb begin
    rx_state_d      = rx_state;
    rx_cnt_d        = rx_cnt;
    rx_idx_d        = rx_idx;
    rx_shift_d      = rx_shift;
    rx_par_bit_d    = rx_par_bit;
    rx_data_d       = rx_data;
    rx_valid_d      = 1'b0;
    rx_parity_err_d = 1'b0;
    rx_frame_err_d  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_line) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Re-check at the start-bit centre; a high line was only a glitch.
        if (rx_cnt == CNT_MID) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = rx_shift_in;
          if (rx_idx == IDX_LAST) begin
            rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx + IDX_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_d     = '0;
          rx_par_bit_d = rx_line;
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            rx_data_d       = rx_shift;
            rx_valid_d      = 1'b1;
            rx_parity_err_d = HAS_PARITY && (rx_par_bit != parity_of(rx_shift));
            rx_state_d      = RX_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            rx_state_d     = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // Ride out a break: no new frame until the line has gone high.
        if (rx_line) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_d;
      rx_cnt        <= rx_cnt_d;
      rx_idx        <= rx_idx_d;
      rx_shift      <= rx_shift_d;
      rx_par_bit    <= rx_par_bit_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      rx_parity_err <= rx_parity_err_d;
      rx_frame_err  <= rx_frame_err_d;
    end
  end

endmodule

// File: tb/tb_serdes_lane.sv
// Bench for serdes_lane: u_dut0 is the no-parity lane (loopback and external
// stimulus), u_dut1 is an even-parity lane driven externally.
module tb_serdes_lane;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data0, rx_data0, tx_data1, rx_data1;
  logic tx_valid0, tx_ready0, tx_serial0, rx_serial0, loopback0;
  logic rx_valid0, rx_parity_err0, rx_frame_err0, tx_busy0;
  logic tx_valid1, tx_ready1, tx_serial1, rx_serial1, loopback1;
  logic rx_valid1, rx_parity_err1, rx_frame_err1, tx_busy1;

  serdes_lane #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_serial(tx_serial0), .rx_serial(rx_serial0),
    .loopback(loopback0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_parity_err(rx_parity_err0), .rx_frame_err(rx_frame_err0), .tx_busy(tx_busy0)
  );

  serdes_lane #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .LSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_serial(tx_serial1), .rx_serial(rx_serial1),
    .loopback(loopback1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_parity_err(rx_parity_err1), .rx_frame_err(rx_frame_err1), .tx_busy(tx_busy1)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int f0 = 0;
  int f1 = 0;

  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;   // first-sent bit is the leftmost
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] w);
    bit seq[$];
    logic [9:0] f;
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(w[i]);
    seq.push_back(1'b1);
    for (int k = 0; k < 10; k++) f[9-k] = seq[k];
    return f;
  endfunction

  // Collect received words and framing errors from both lanes.
  always @(negedge clk) begin
    if (rx_valid0 || rx_frame_err0)
      check("d0_valid_ferr_exclusive", 32'(rx_valid0 & rx_frame_err0), 32'd0);
    if (rx_valid1 || rx_frame_err1)
      check("d1_valid_ferr_exclusive", 32'(rx_valid1 & rx_frame_err1), 32'd0);
    if (rx_valid0) q0.push_back({rx_parity_err0, rx_data0});
    if (rx_valid1) q1.push_back({rx_parity_err1, rx_data1});
    if (rx_frame_err0) f0++;
    if (rx_frame_err1) f1++;
  end

  task automatic wait_rx(input int sel, input logic [7:0] w, input logic perr, input string name);
    int n = 0;
    bit got = 1'b0;
    logic [8:0] e = '0;
    while (!got && n < 60) begin
      if (sel == 0 && q0.size() > 0) begin
        e = q0.pop_front(); got = 1'b1;
      end else if (sel == 1 && q1.size() > 0) begin
        e = q1.pop_front(); got = 1'b1;
      end else begin
        @(negedge clk); n++;
      end
    end
    check({name, "_arrived"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_rx_data"}, 32'(e[7:0]), 32'(w));
      check({name, "_rx_parity_err"}, 32'(e[8]), 32'(perr));
    end
  endtask

  // Send one word on lane 0 in loopback and watch its frame bit by bit.
  task automatic send_loop(input logic [7:0] w, input logic [9:0] frame, input string name);
    int not_busy = 0;
    @(negedge clk);
    check({name, "_ready_before"}, 32'(tx_ready0), 32'd1);
    tx_data0 = w;
    tx_valid0 = 1'b1;
    @(posedge clk);
    #1 tx_valid0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      int match = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (tx_serial0 === frame[9-k]) match++;
        if (tx_ready0 !== 1'b0 || tx_busy0 !== 1'b1) not_busy++;
      end
      check($sformatf("%s_bit%0d_cycles", name, k), 32'(match), 32'(CPB));
    end
    check({name, "_not_busy_cycles"}, 32'(not_busy), 32'd0);
    @(negedge clk);
    check({name, "_ready_after"}, 32'(tx_ready0), 32'd1);
    check({name, "_busy_after"}, 32'(tx_busy0), 32'd0);
    wait_rx(0, w, 1'b0, name);
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx_serial0 = b;
    else rx_serial1 = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drive an external frame on rx_serial of the chosen lane.
  task automatic drive_ext(input int sel, input logic [7:0] w, input bit has_par,
                           input logic par, input logic stop);
    set_line(sel, 1'b0);
    for (int i = 0; i < 8; i++) set_line(sel, w[i]);
    if (has_par) set_line(sel, par);
    set_line(sel, stop);
  endtask

  vec_t vecs[5];
  logic [7:0] b2b[3];

  initial begin
    int fs;
    int low;
    logic [7:0] w;
    logic p;

    vecs[0] = '{word: 8'hA5, frame: 10'b0101001011};
    vecs[1] = '{word: 8'h00, frame: 10'b0000000001};
    vecs[2] = '{word: 8'hFF, frame: 10'b0111111111};
    vecs[3] = '{word: 8'h3C, frame: 10'b0001111001};
    vecs[4] = '{word: 8'h12, frame: 10'b0010010001};
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;

    tx_data0 = '0; tx_valid0 = 1'b0; rx_serial0 = 1'b1; loopback0 = 1'b1;
    tx_data1 = '0; tx_valid1 = 1'b0; rx_serial1 = 1'b1; loopback1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_tx_serial", 32'(tx_serial0), 32'd1);
    check("rst_tx_ready", 32'(tx_ready0), 32'd1);
    check("rst_tx_busy", 32'(tx_busy0), 32'd0);
    check("rst_rx_data", 32'(rx_data0), 32'd0);
    check("rst_rx_valid", 32'(rx_valid0), 32'd0);
    check("rst_rx_parity_err", 32'(rx_parity_err0), 32'd0);
    check("rst_rx_frame_err", 32'(rx_frame_err0), 32'd0);
    check("rst_d1_rx_data", 32'(rx_data1), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven loopback frames
    for (int i = 0; i < 5; i++) send_loop(vecs[i].word, vecs[i].frame, $sformatf("vec%0d", i));

    // Back-to-back with tx_valid held high
    q0.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tx_data0 = b2b[i];
      tx_valid0 = 1'b1;
      low = 0;
      @(negedge clk);
      while (tx_ready0 !== 1'b1 && low < 100) begin
        low++;
        @(negedge clk);
      end
      check($sformatf("b2b%0d_ready_low_cycles", i), 32'(low), 32'd40);
    end
    tx_valid0 = 1'b0;
    for (int i = 0; i < 3; i++) wait_rx(0, b2b[i], 1'b0, $sformatf("b2b%0d", i));

    // Even parity on lane 1: 0x07 has three ones, so the correct bit is 1
    drive_ext(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_rx(1, 8'h07, 1'b1, "par_bad");
    drive_ext(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_rx(1, 8'h07, 1'b0, "par_good");

    // Framing error followed by a long break
    loopback0 = 1'b0;
    rx_serial0 = 1'b1;
    repeat (6) @(negedge clk);
    q0.delete();
    fs = f0;
    drive_ext(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    check("frame_err_count", 32'(f0 - fs), 32'd1);
    check("frame_no_valid", 32'(q0.size()), 32'd0);
    rx_serial0 = 1'b1;
    repeat (8) @(negedge clk);
    check("frame_err_after_break", 32'(f0 - fs), 32'd1);
    drive_ext(0, 8'h12, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 8'h12, 1'b0, "frame_recover");
    check("frame_err_after_recover", 32'(f0 - fs), 32'd1);

    // One-cycle glitch must be rejected
    repeat (4) @(negedge clk);
    q0.delete();
    fs = f0;
    rx_serial0 = 1'b0;
    @(negedge clk);
    rx_serial0 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", 32'(q0.size()), 32'd0);
    check("glitch_no_ferr", 32'(f0 - fs), 32'd0);
    check("glitch_rx_data_held", 32'(rx_data0), 32'h12);
    drive_ext(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 8'h81, 1'b0, "glitch_recover");

    // Reset during TX data bit 3 (bit 3 of 0xA5 is 0)
    loopback0 = 1'b1;
    repeat (4) @(negedge clk);
    q0.delete();
    fs = f0;
    tx_data0 = 8'hA5;
    tx_valid0 = 1'b1;
    @(posedge clk);
    #1 tx_valid0 = 1'b0;
    repeat (18) @(negedge clk);
    check("midrst_bit3_before", 32'(tx_serial0), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst_tx_serial", 32'(tx_serial0), 32'd1);
    check("midrst_tx_ready", 32'(tx_ready0), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_no_valid", 32'(q0.size()), 32'd0);
    check("midrst_no_ferr", 32'(f0 - fs), 32'd0);
    send_loop(8'h3C, 10'b0001111001, "post_rst");

    // Random loopback words against the frame model
    for (int n = 0; n < 12; n++) begin
      w = 8'($urandom);
      send_loop(w, model_frame(w), $sformatf("rand_loop%0d", n));
    end

    // Random external parity frames on lane 1
    for (int n = 0; n < 12; n++) begin
      w = 8'($urandom);
      p = 1'($urandom_range(1, 0));
      drive_ext(1, w, 1'b1, p, 1'b1);
      wait_rx(1, w, 1'(p != 1'($countones(w) % 2)), $sformatf("rand_par%0d", n));
    end
    check("d1_no_frame_err", 32'(f1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
